regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register file's single write port between two producers: the in-order pipeline writeback stage (WB), and one long-latency unit (LL) such as the divider or the load path. WB results get the port immediately. LL results queue in a small FIFO and write whenever WB leaves the port idle. A bounded-wait counter stalls the pipeline so queued LL results cannot starve. Combinational hazard lookup flags reads of registers that still have a queued write. The block sits between the execute/writeback logic and the register file's write_enable, write_reg and write_data inputs.

## Interface
- DEPTH, 2: LL FIFO entries; power of two, ≥2.
- MAX_WAIT, 4: consecutive ungranted cycles of a FIFO head before the pipeline is stalled; ≥1.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB result present this cycle.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB result.
- ll_valid  in  1  LL result offered.
- ll_ready  out  1  FIFO can accept; transfer occurs when ll_valid && ll_ready.
- ll_rd  in  5  LL destination register.
- ll_data  in  32  LL result.
- chk_reg1, chk_reg2  in  5 each  source registers being decoded.
- hazard  out  1  a queued LL entry targets a nonzero chk_reg.
- pipe_stall  out  1  registered; pipeline must present wb_valid=0 this cycle.
- rf_write_enable  out  1  to register file write_enable.
- rf_write_reg  out  5  to register file write_reg.
- rf_write_data  out  32  to register file write_data.
- proto_err  out  1  sticky; wb_valid seen while pipe_stall=1.

## Operation
- State: FIFO storage {rd, data} × DEPTH, rd/wr pointers (wrap modulo DEPTH), count (0..DEPTH), wait_cnt, pipe_stall, proto_err.
- Grant (combinational):
  - wb_write = wb_valid && wb_rd≠0 && !pipe_stall.
  - fifo_pop = count>0 && !wb_write.
- Write port:
  - If wb_write: enable=1, reg=wb_rd, data=wb_data.
  - Else if fifo_pop && head.rd≠0: enable=1, reg=head.rd, data=head.data.
  - Else enable=0; reg and data are don't-care, driven 0.
- x0: WB with rd=0 is treated as port idle. A FIFO head with rd=0 is popped with no write.
- ll_ready = !reset && count<DEPTH. No pass-through: a push never bypasses to the port in the same cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- wait_cnt:
  - Clears to 0 on pop or when count=0.
  - Otherwise increments, saturating at MAX_WAIT.
- pipe_stall:
  - Next value = count>0 && !fifo_pop && wait_cnt+1 ≥ MAX_WAIT.
  - While pipe_stall=1, wb_write is forced 0, so the head pops. The stall therefore lasts exactly one cycle per starvation event.
- proto_err is set when wb_valid && pipe_stall; it clears only on reset. The WB result in that cycle is dropped.
- hazard = OR over valid entries of (entry.rd≠0 && (entry.rd==chk_reg1 || entry.rd==chk_reg2)).

## Timing
- Reset values: count=0, pointers=0, wait_cnt=0, pipe_stall=0, proto_err=0, rf_write_enable=0, hazard=0, ll_ready=0 while reset=1.
- Reset mid-operation flushes all queued entries with no write.
- WB → port: 0 cycles (combinational).
- LL → port: ≥1 cycle. An entry accepted in cycle N can write in cycle N+1 at the earliest.
- Worst-case head wait: MAX_WAIT ungranted cycles, then the stall cycle forces the write.
- hazard reflects the current FIFO contents. An entry popped this cycle still flags hazard this cycle; the register file's write-then-read ordering covers the next cycle.

## Test plan
- Reset, then hold idle: all outputs 0 and ll_ready=1. LL push {rd=5, data=0xDEAD_BEEF} in cycle 0 → cycle 1 shows enable=1, reg=5, data=0xDEADBEEF.
- Simultaneous inputs: WB {rd=3, data=0x11} and LL {rd=4, data=0x22} both valid in cycle 0 → cycle 0 writes x3. Cycle 1, with WB idle, writes x4.
- Starvation: continuous WB writes (rd≠0) with one LL entry queued, MAX_WAIT=4 → pipe_stall=1 exactly once, on the 5th cycle after the push. That cycle writes the LL entry and pipe_stall returns to 0 the next cycle.
- Full FIFO: push 2 entries while WB is busy → ll_ready=0. Enable a simultaneous push and pop at count=2 → no push accepted; no entry lost or overwritten.
- x0 and hazard: LL {rd=0} is popped with rf_write_enable=0. LL {rd=7} queued with chk_reg2=7 → hazard=1. chk_reg1=0 with an rd=0 entry queued → hazard=0.
- Mid-stream reset: reset asserted with 2 entries queued → no further writes and count=0. Drive wb_valid during pipe_stall → proto_err=1, held until reset.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register-file write port between the WB stage and one long-latency (LL) unit.
// Latency: WB writes combinationally in its own cycle; an LL result writes one or more cycles after acceptance.
// Backpressure: ll_ready drops when the FIFO is full. pipe_stall idles WB for one cycle after MAX_WAIT missed grants.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   wb_valid/wb_rd/wb_data      writeback result; it always wins the port unless stalled
//   ll_valid/ll_ready/ll_rd/ll_data  long-latency result; it is queued with a valid/ready handshake
//   chk_reg1/chk_reg2, hazard   source-register lookup against the queued LL writes
//   pipe_stall                  registered; the pipeline must hold wb_valid low while it is high
//   rf_write_*                  register-file write port
//   proto_err                   sticky; set when wb_valid is seen during pipe_stall
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        hazard,
  output logic        pipe_stall,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [WW:0]   MAX_WAIT_C = (WW+1)'(MAX_WAIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;

  logic          push;
  logic          wb_write;
  logic          fifo_pop;
  logic          stall_nxt;
  entry_t        head;
  logic [PW-1:0] offs [DEPTH];

  // Reset holds the port idle, so a flush in progress never leaks a write.
  assign ll_ready = !reset && (count < DEPTH_C);
  assign push     = ll_valid && ll_ready;
  assign wb_write = !reset && wb_valid && (wb_rd != 5'd0) && !pipe_stall;
  assign fifo_pop = !reset && (count != '0) && !wb_write;
  assign head     = mem[rd_ptr];

  // The head has waited wait_cnt cycles so far. If it misses again this
  // cycle, it has waited MAX_WAIT cycles, and the next cycle is a forced stall.
  assign stall_nxt = (count != '0) && !fifo_pop &&
                     (({1'b0, wait_cnt} + 1'b1) >= MAX_WAIT_C);

  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    if (wb_write) begin
      rf_write_enable = 1'b1;
      rf_write_reg    = wb_rd;
      rf_write_data   = wb_data;
    end else if (fifo_pop && (head.rd != 5'd0)) begin
      rf_write_enable = 1'b1;
      rf_write_reg    = head.rd;
      rf_write_data   = head.data;
    end
  end

  // An entry is live when its distance from the read pointer, taken modulo
  // DEPTH, is less than count. The head being popped this cycle still counts.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = PW'(i) - rd_ptr;
      if (({1'b0, offs[i]} < count) && (mem[i].rd != 5'd0) &&
          ((mem[i].rd == chk_reg1) || (mem[i].rd == chk_reg2)))
        hazard = 1'b1;
    end
    if (reset)
      hazard = 1'b0;
  end

  // Storage needs no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{rd: ll_rd, data: ll_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wait_cnt   <= '0;
      pipe_stall <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (fifo_pop || (count == '0))
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;

      pipe_stall <= stall_nxt;

      if (wb_valid && pipe_stall)
        proto_err <= 1'b1;
    end
  end

endmodule
